// File: rtl/decoder_scan_ctrl.sv
// Steps the decoder_2x4 select through its four codes, holding each for a latched dwell time.
// Optional DECODER_SCAN_REVERSE_DIR_EN adds a `dir` input for a downward 11->00 scan.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
`ifdef DECODER_SCAN_REVERSE_DIR_EN
    input  logic               dir,
`endif
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         w,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               step
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]         state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] reload_l;
    logic               mode_l;
    logic               dir_l;
    logic               dir_in;
    logic [DWELL_W-1:0] reload_in;
    logic [1:0]         first_in;
    logic [1:0]         last_code;
    logic [1:0]         next_code;

`ifdef DECODER_SCAN_REVERSE_DIR_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    // The counter counts down to zero, so a code lasting N cycles reloads with N-1.
    assign reload_in = (dwell == '0) ? '0 : dwell - 1'b1;
    assign first_in  = {2{dir_in}};
    assign last_code = ~{2{dir_l}};
    assign next_code = dir_l ? w - 2'd1 : w + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            w        <= 2'b00;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step     <= 1'b0;
            cnt      <= '0;
            reload_l <= '0;
            mode_l   <= 1'b0;
            dir_l    <= 1'b0;
        end else begin
            done <= 1'b0;
            step <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state    <= S_SCAN;
                        w        <= first_in;
                        en       <= 1'b1;
                        busy     <= 1'b1;
                        step     <= 1'b1;
                        cnt      <= reload_in;
                        reload_l <= reload_in;
                        mode_l   <= mode;
                        dir_l    <= dir_in;
                    end
                end
                S_SCAN: begin
                    if (stop) begin
                        state <= S_IDLE;
                        w     <= 2'b00;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (w != last_code) begin
                        w    <= next_code;
                        cnt  <= reload_l;
                        step <= 1'b1;
                    end else if (!mode_l) begin
                        state <= S_IDLE;
                        w     <= 2'b00;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Continuous wrap: pick up fresh dwell/dir for the next pass.
                        w        <= first_in;
                        cnt      <= reload_in;
                        reload_l <= reload_in;
                        dir_l    <= dir_in;
                        step     <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomized bench for decoder_scan_ctrl against a per-pass schedule model.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [1:0] w;
    logic       en, busy, done, step;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
`ifdef DECODER_SCAN_REVERSE_DIR_EN
        .dir   (dir),
`endif
        .mode  (mode),
        .dwell (dwell),
        .w     (w),
        .en    (en),
        .busy  (busy),
        .done  (done),
        .step  (step)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a queue holding one entry per upcoming presented cycle of the current pass.
    typedef struct {
        logic [1:0] code;
        bit         first;
    } ent_t;

    ent_t q[$];
    bit   m_scan = 0;
    bit   m_mode = 0;
    bit   m_done = 0;

    function automatic void build_pass(input int d, input bit rev);
        int n;
        ent_t e;
        n = (d == 0) ? 1 : d;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < n; r++) begin
                e.code  = rev ? 2'(3 - k) : 2'(k);
                e.first = (r == 0);
                q.push_back(e);
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_scan = 0;
            m_done = 0;
        end else if (m_scan) begin
            m_done = 0;
            if (stop) begin
                q.delete();
                m_scan = 0;
            end else begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    if (m_mode) build_pass(int'(dwell), dir);
                    else begin
                        m_scan = 0;
                        m_done = 1;
                    end
                end
            end
        end else begin
            m_done = 0;
            if (start && !stop) begin
                m_mode = mode;
                build_pass(int'(dwell), dir);
                m_scan = 1;
            end
        end
        #1;
        check("w",    {30'd0, w},    m_scan ? {30'd0, q[0].code} : 32'd0);
        check("en",   {31'd0, en},   {31'd0, m_scan});
        check("busy", {31'd0, busy}, {31'd0, m_scan});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("step", {31'd0, step}, (m_scan && q[0].first) ? 32'd1 : 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_code(input logic [1:0] c, input string tag);
        int k;
        k = 0;
        while (w !== c && k < 100) begin
            cycle();
            k++;
        end
        check(tag, {30'd0, w}, {30'd0, c});
    endtask

    initial begin
        run(2);
        reset = 1'b0;
        run(1);

        // One-shot, dwell 3.
        mode = 1'b0; dwell = 8'd3; start = 1'b1;
        cycle();
        start = 1'b0;
        run(15);

        // dwell 0 behaves as dwell 1.
        dwell = 8'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        run(6);

        // Continuous, dwell changed mid-pass takes effect at the wrap.
        mode = 1'b1; dwell = 8'd2; start = 1'b1;
        cycle();
        start = 1'b0;
        run(3);
        dwell = 8'd1;
        run(14);
        wait_code(2'b10, "reach_10");
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run(2);

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1;
        run(3);
        start = 1'b0; stop = 1'b0;

        // Reset mid-scan with start held.
        dwell = 8'd3; start = 1'b1;
        cycle();
        wait_code(2'b01, "reach_01");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(4);
        start = 1'b0;
        run(12);

        // Back-to-back one-shot passes, start held through done.
        mode = 1'b0; dwell = 8'd1; start = 1'b1;
        run(12);
        start = 1'b0;
        run(3);

`ifdef DECODER_SCAN_REVERSE_DIR_EN
        dir = 1'b1; mode = 1'b0; dwell = 8'd1; start = 1'b1;
        cycle();
        start = 1'b0;
        run(6);
        dir = 1'b0;
`endif

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 40) == 0);
            reset = ($urandom_range(0, 300) == 0);
            mode  = $urandom_range(0, 1) == 1;
            dwell = 8'($urandom_range(0, 4));
`ifdef DECODER_SCAN_REVERSE_DIR_EN
            dir   = $urandom_range(0, 1) == 1;
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
